// File: rtl/swm_tx_adapter.sv
// swm_tx_adapter: Avalon-ST 32-bit sink -> SerialLite III 256-bit source with burst framing repair.
// Optional feature macro SWM_TX_STATS_EN adds saturating pkt_count / err_count outputs.
module swm_tx_adapter #(
  parameter int         MAX_BURST_BEATS = 256,
  parameter logic [7:0] SYNC_VALUE      = 8'h00
) (
  input  logic         clk_in_clk,
  input  logic         reset_in_rst,
  input  logic [31:0]  avalonst_sink_data,
  input  logic         avalonst_sink_valid,
  input  logic         avalonst_sink_startofpacket,
  input  logic         avalonst_sink_endofpacket,
  output logic         avalonst_sink_ready,
  output logic [255:0] data_tx,
  output logic         valid_tx,
  output logic         start_of_burst_tx,
  output logic         end_of_burst_tx,
  output logic [7:0]   sync_tx,
  input  logic         ready_tx,
  input  logic         link_up_tx,
  output logic         framing_err
`ifdef SWM_TX_STATS_EN
  ,
  output logic [31:0]  pkt_count,
  output logic [31:0]  err_count
`endif
);

  localparam int CW = $clog2(MAX_BURST_BEATS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, IN_PKT = 2'd1, DROP = 2'd2} state_t;

  state_t          state_r, state_n;
  logic [CW-1:0]   count_r, count_n;
  logic            hold_v_r, hold_v_n;
  logic [33:0]     hold_r;
  logic [33:0]     fifo_mem_r [2];
  logic            rd_ptr_r, wr_ptr_r;
  logic [1:0]      fifo_cnt_r, fifo_cnt_n;
  logic            ready_r, ready_n;
  logic            err_r, err_s;

  logic            accept_s, pop_s, emit_s, flush_s, hold_eob_s, new_eob_s;
  logic            direct_s, to_hold_s;
  logic [1:0]      npush_s;
  logic [33:0]     held_s, new_s, slot0_s, slot1_s, head_s;

  // Entries are {sob, eob, word}.
  assign accept_s = avalonst_sink_valid & ready_r;
  assign head_s   = fifo_mem_r[rd_ptr_r];
  assign valid_tx = link_up_tx & (fifo_cnt_r != 2'd0);
  assign pop_s    = valid_tx & ready_tx;

  assign avalonst_sink_ready = ready_r;
  assign framing_err         = err_r;
  assign sync_tx             = SYNC_VALUE;
  assign data_tx             = {224'd0, head_s[31:0]};
  assign start_of_burst_tx   = (fifo_cnt_r != 2'd0) & head_s[33];
  assign end_of_burst_tx     = (fifo_cnt_r != 2'd0) & head_s[32];

  // Framing FSM: decides per accepted beat whether it is emitted, repaired or dropped.
  always_comb begin
    state_n    = state_r;
    count_n    = count_r;
    err_s      = 1'b0;
    emit_s     = 1'b0;
    flush_s    = 1'b0;
    hold_eob_s = 1'b0;
    new_eob_s  = avalonst_sink_endofpacket;
    if (accept_s) begin
      case (state_r)
        IDLE, DROP: begin
          if (avalonst_sink_startofpacket) begin
            emit_s = 1'b1;
            if (avalonst_sink_endofpacket) begin
              state_n = IDLE;
              count_n = {CW{1'b0}};
            end else begin
              state_n = IN_PKT;
              count_n = CW'(1);
            end
          end else begin
            // Only the first stray beat of a drop run is reported.
            err_s   = (state_r == IDLE);
            state_n = avalonst_sink_endofpacket ? IDLE : DROP;
            count_n = {CW{1'b0}};
          end
        end
        IN_PKT: begin
          emit_s  = 1'b1;
          flush_s = hold_v_r;
          if (avalonst_sink_startofpacket) begin
            hold_eob_s = 1'b1;
            err_s      = 1'b1;
            if (avalonst_sink_endofpacket) begin
              state_n = IDLE;
              count_n = {CW{1'b0}};
            end else begin
              state_n = IN_PKT;
              count_n = CW'(1);
            end
          end else if (avalonst_sink_endofpacket) begin
            state_n = IDLE;
            count_n = {CW{1'b0}};
          end else if (count_r == CW'(MAX_BURST_BEATS - 1)) begin
            new_eob_s = 1'b1;
            err_s     = 1'b1;
            state_n   = DROP;
            count_n   = {CW{1'b0}};
          end else begin
            count_n = count_r + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          count_n = {CW{1'b0}};
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Push selection: the held beat always goes ahead of the incoming one.
  always_comb begin
    held_s    = {hold_r[33], hold_r[32] | hold_eob_s, hold_r[31:0]};
    new_s     = {avalonst_sink_startofpacket, new_eob_s, avalonst_sink_data};
    direct_s  = emit_s & new_eob_s;
    to_hold_s = emit_s & ~new_eob_s;
    if (flush_s) begin
      slot0_s = held_s;
      slot1_s = new_s;
      npush_s = direct_s ? 2'd2 : 2'd1;
    end else begin
      slot0_s = new_s;
      slot1_s = new_s;
      npush_s = direct_s ? 2'd1 : 2'd0;
    end
    fifo_cnt_n = fifo_cnt_r + npush_s - {1'b0, pop_s};
    hold_v_n   = to_hold_s | (hold_v_r & ~flush_s);
    // Ready only when the worst-case next accept (held beat + EOP beat) is guaranteed to fit.
    ready_n    = link_up_tx & (({1'b0, fifo_cnt_n} + {2'b00, hold_v_n}) <= 3'd1);
  end

  // FSM state and burst beat counter.
  always_ff @(posedge clk_in_clk or posedge reset_in_rst) begin
    if (reset_in_rst) begin
      state_r <= IDLE;
      count_r <= {CW{1'b0}};
    end else begin
      state_r <= state_n;
      count_r <= count_n;
    end
  end

  // Hold register for the most recent non-EOP beat.
  always_ff @(posedge clk_in_clk or posedge reset_in_rst) begin
    if (reset_in_rst) begin
      hold_v_r <= 1'b0;
      hold_r   <= 34'd0;
    end else begin
      hold_v_r <= hold_v_n;
      if (to_hold_s) begin
        hold_r <= new_s;
      end
    end
  end

  // Two-entry output FIFO.
  always_ff @(posedge clk_in_clk or posedge reset_in_rst) begin
    if (reset_in_rst) begin
      fifo_mem_r[0] <= 34'd0;
      fifo_mem_r[1] <= 34'd0;
      rd_ptr_r      <= 1'b0;
      wr_ptr_r      <= 1'b0;
      fifo_cnt_r    <= 2'd0;
    end else begin
      if (npush_s != 2'd0) begin
        fifo_mem_r[wr_ptr_r] <= slot0_s;
      end
      if (npush_s == 2'd2) begin
        fifo_mem_r[~wr_ptr_r] <= slot1_s;
      end
      wr_ptr_r   <= wr_ptr_r ^ npush_s[0];
      rd_ptr_r   <= rd_ptr_r ^ pop_s;
      fifo_cnt_r <= fifo_cnt_n;
    end
  end

  // Registered sink ready and framing error pulse.
  always_ff @(posedge clk_in_clk or posedge reset_in_rst) begin
    if (reset_in_rst) begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= ready_n;
      err_r   <= err_s;
    end
  end

`ifdef SWM_TX_STATS_EN
  logic [31:0] pkt_count_r, err_count_r;

  assign pkt_count = pkt_count_r;
  assign err_count = err_count_r;

  // Saturating packet and framing-error counters.
  always_ff @(posedge clk_in_clk or posedge reset_in_rst) begin
    if (reset_in_rst) begin
      pkt_count_r <= 32'd0;
      err_count_r <= 32'd0;
    end else begin
      if (pop_s && head_s[32] && (pkt_count_r != 32'hFFFF_FFFF)) begin
        pkt_count_r <= pkt_count_r + 32'd1;
      end
      if (err_r && (err_count_r != 32'hFFFF_FFFF)) begin
        err_count_r <= err_count_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_swm_tx_adapter.sv
// Directed self-checking bench for swm_tx_adapter (built with MAX_BURST_BEATS=4).
// Stats outputs are checked only when SWM_TX_STATS_EN is defined.
module tb_swm_tx_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s_data;
  logic         s_valid, s_sop, s_eop;
  logic         s_ready;
  logic [255:0] data_tx;
  logic         valid_tx, sob_tx, eob_tx;
  logic [7:0]   sync_tx;
  logic         ready_tx, link_up_tx;
  logic         framing_err;
`ifdef SWM_TX_STATS_EN
  logic [31:0]  pkt_count, err_count;
`endif

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int err_seen = 0;
  logic [33:0] got_q [$];

  swm_tx_adapter #(.MAX_BURST_BEATS(4), .SYNC_VALUE(8'hA5)) dut (
    .clk_in_clk                  (clk),
    .reset_in_rst                (rst),
    .avalonst_sink_data          (s_data),
    .avalonst_sink_valid         (s_valid),
    .avalonst_sink_startofpacket (s_sop),
    .avalonst_sink_endofpacket   (s_eop),
    .avalonst_sink_ready         (s_ready),
    .data_tx                     (data_tx),
    .valid_tx                    (valid_tx),
    .start_of_burst_tx           (sob_tx),
    .end_of_burst_tx             (eob_tx),
    .sync_tx                     (sync_tx),
    .ready_tx                    (ready_tx),
    .link_up_tx                  (link_up_tx),
    .framing_err                 (framing_err)
`ifdef SWM_TX_STATS_EN
    ,
    .pkt_count                   (pkt_count),
    .err_count                   (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Output monitor: samples mid-cycle what will pop on the next rising edge.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (valid_tx && ready_tx) got_q.push_back({sob_tx, eob_tx, data_tx[31:0]});
      if (framing_err) err_seen++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [33:0] exp);
    logic [33:0] obs;
    obs = 34'h3_FFFF_FFFF;
    if (i < got_q.size()) obs = got_q[i];
    chk(tag, {30'd0, obs}, {30'd0, exp});
  endtask

  task automatic send(input logic [31:0] d, input logic sop, input logic eop);
    int n;
    n = 0;
    @(negedge clk);
    s_data = d; s_sop = sop; s_eop = eop; s_valid = 1'b1;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
  endtask

  task automatic drain_and_clear_start();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; s_data = 32'd0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    ready_tx = 1'b1; link_up_tx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_valid", {63'd0, valid_tx}, 64'd0);
    chk("rst_sob_eob", {62'd0, sob_tx, eob_tx}, 64'd0);
    chk("rst_ferr", {63'd0, framing_err}, 64'd0);
    chk("rst_data", {63'd0, |data_tx}, 64'd0);
    chk("rst_sync", {56'd0, sync_tx}, 64'hA5);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, s_ready}, 64'd1);

    // 1: clean 4-beat packet
    send(32'h10, 1'b1, 1'b0); send(32'h11, 1'b0, 1'b0);
    send(32'h12, 1'b0, 1'b0); send(32'h13, 1'b0, 1'b1);
    drain_and_clear_start();
    chk("t1_n", got_q.size(), 64'd4);
    chk_beat("t1_b0", 0, {2'b10, 32'h10});
    chk_beat("t1_b1", 1, {2'b00, 32'h11});
    chk_beat("t1_b2", 2, {2'b00, 32'h12});
    chk_beat("t1_b3", 3, {2'b01, 32'h13});
    chk("t1_ferr", err_seen, 64'd0);
    chk("t1_upper", {63'd0, |data_tx[255:32]}, 64'd0);
    got_q.delete(); err_seen = 0;

    // 2: stray beat in IDLE dropped, then good packet
    send(32'hAA, 1'b0, 1'b0);
    send(32'h20, 1'b1, 1'b0); send(32'h21, 1'b0, 1'b1);
    drain_and_clear_start();
    chk("t2_n", got_q.size(), 64'd2);
    chk_beat("t2_b0", 0, {2'b10, 32'h20});
    chk_beat("t2_b1", 1, {2'b01, 32'h21});
    chk("t2_ferr", err_seen, 64'd1);
    got_q.delete(); err_seen = 0;

    // 3: SOP mid-packet closes the previous burst
    send(32'h1, 1'b1, 1'b0); send(32'h2, 1'b0, 1'b0);
    send(32'h3, 1'b1, 1'b0); send(32'h4, 1'b0, 1'b1);
    drain_and_clear_start();
    chk("t3_n", got_q.size(), 64'd4);
    chk_beat("t3_b0", 0, {2'b10, 32'h1});
    chk_beat("t3_b1", 1, {2'b01, 32'h2});
    chk_beat("t3_b2", 2, {2'b10, 32'h3});
    chk_beat("t3_b3", 3, {2'b01, 32'h4});
    chk("t3_ferr", err_seen, 64'd1);
    got_q.delete(); err_seen = 0;

    // 4: 6-beat packet against a 4-beat cap
    send(32'h40, 1'b1, 1'b0); send(32'h41, 1'b0, 1'b0); send(32'h42, 1'b0, 1'b0);
    send(32'h43, 1'b0, 1'b0); send(32'h44, 1'b0, 1'b0); send(32'h45, 1'b0, 1'b1);
    drain_and_clear_start();
    chk("t4_n", got_q.size(), 64'd4);
    chk_beat("t4_b0", 0, {2'b10, 32'h40});
    chk_beat("t4_b1", 1, {2'b00, 32'h41});
    chk_beat("t4_b2", 2, {2'b00, 32'h42});
    chk_beat("t4_b3", 3, {2'b01, 32'h43});
    chk("t4_ferr", err_seen, 64'd1);
    got_q.delete(); err_seen = 0;

    // 5: core backpressure mid-packet
    ready_tx = 1'b0;
    send(32'h50, 1'b1, 1'b0); send(32'h51, 1'b0, 1'b0);
    chk("t5_sink_low", {63'd0, s_ready}, 64'd0);
    chk("t5_head0", {30'd0, valid_tx, sob_tx, data_tx[31:0]}, {30'd0, 2'b11, 32'h50});
    repeat (10) @(negedge clk);
    chk("t5_head10", {30'd0, valid_tx, sob_tx, data_tx[31:0]}, {30'd0, 2'b11, 32'h50});
    chk("t5_sink_still_low", {63'd0, s_ready}, 64'd0);
    chk("t5_none_popped", got_q.size(), 64'd0);
    ready_tx = 1'b1;
    send(32'h52, 1'b0, 1'b0); send(32'h53, 1'b0, 1'b1);
    drain_and_clear_start();
    chk("t5_n", got_q.size(), 64'd4);
    chk_beat("t5_b0", 0, {2'b10, 32'h50});
    chk_beat("t5_b1", 1, {2'b00, 32'h51});
    chk_beat("t5_b2", 2, {2'b00, 32'h52});
    chk_beat("t5_b3", 3, {2'b01, 32'h53});
    chk("t5_ferr", err_seen, 64'd0);
    got_q.delete(); err_seen = 0;

    // 6: link drop then reset in the middle of a packet
    send(32'h60, 1'b1, 1'b0); send(32'h61, 1'b0, 1'b0);
    link_up_tx = 1'b0;
    #1;
    chk("t6_valid_linkdown", {63'd0, valid_tx}, 64'd0);
    @(negedge clk);
    chk("t6_sink_linkdown", {63'd0, s_ready}, 64'd0);
`ifdef SWM_TX_STATS_EN
    chk("t6_pkt_count", pkt_count, 64'd6);
    chk("t6_err_count", err_count, 64'd3);
`endif
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {63'd0, valid_tx}, 64'd0);
    chk("t6_rst_sink", {63'd0, s_ready}, 64'd0);
    chk("t6_rst_ferr_data", {63'd0, framing_err | (|data_tx)}, 64'd0);
`ifdef SWM_TX_STATS_EN
    chk("t6_rst_counts", {pkt_count, err_count}, 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0; link_up_tx = 1'b1;
    @(negedge clk);
    send(32'h71, 1'b1, 1'b1);
    drain_and_clear_start();
    chk("t6_n", got_q.size(), 64'd1);
    chk_beat("t6_b0", 0, {2'b11, 32'h71});
    chk("t6_ferr", err_seen, 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
